// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY,
        DRAIN
    } arb_state_t;

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned PERF_W   = 32;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Saturating event counter with enable, used for per-requester wait statistics.
module mem_arb_perf_cnt
    import mem_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [PERF_W-1:0] count_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (en_i && (count_o != '1)) begin
            count_o <= count_o + PERF_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetch and MEM data access onto one single-port memory.
// Optional wait-cycle counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_if_wait_o,
    output logic [PERF_W-1:0] perf_dm_wait_o
`endif
);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_q;
    logic                if_ack_q, dm_ack_q;
    logic                if_elig, dm_elig;
    logic                grant_if, grant_dm;

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        // A requester in its ack cycle is still holding the old request.
        if_elig  = if_req_i & ~if_ack_q & ~flush_i;
        dm_elig  = dm_req_i & ~dm_ack_q;
        case (state_q)
            IDLE: begin
                if (if_elig && (!dm_elig || (starve_q == STARVE_W'(STARVE_MAX)))) begin
                    grant_if = 1'b1;
                    state_d  = IF_BUSY;
                end else if (dm_elig) begin
                    grant_dm = 1'b1;
                    state_d  = DM_BUSY;
                end
            end
            IF_BUSY: begin
                if (mem_ack_i)    state_d = IDLE;
                else if (flush_i) state_d = DRAIN;
            end
            DM_BUSY: if (mem_ack_i) state_d = IDLE;
            DRAIN:   if (mem_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else if (!if_req_i || grant_if) begin
            starve_q <= '0;
        end else if (grant_dm && (starve_q != STARVE_W'(STARVE_MAX))) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            if (grant_if) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= if_addr_i;
                mem_wdata_o <= '0;
            end else if (grant_dm) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= dm_we_i;
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
            end else if (mem_ack_i && (state_q != IDLE)) begin
                mem_req_o <= 1'b0;
                // A fetch flushed in its completion cycle is dropped like DRAIN.
                if ((state_q == IF_BUSY) && !flush_i) begin
                    if_rdata_o <= mem_rdata_i;
                    if_ack_q   <= 1'b1;
                end
                if (state_q == DM_BUSY) begin
                    dm_rdata_o <= mem_rdata_i;
                    dm_ack_q   <= 1'b1;
                end
            end
        end
    end

    assign if_ack_o = if_ack_q & ~flush_i;
    assign dm_ack_o = dm_ack_q;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf_cnt u_perf_if (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (if_req_i & ~if_ack_o),
        .count_o (perf_if_wait_o)
    );

    mem_arb_perf_cnt u_perf_dm (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (dm_req_i & ~dm_ack_o),
        .count_o (perf_dm_wait_o)
    );
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF-stage fetch and the MEM-stage data access of the 5-stage pipeline.
- Sequences each access with a registered request/acknowledge handshake to the memory.
- Exports per-requester acks that the pipeline turns into stalls.
- Discards an in-flight fetch when a taken branch flushes IF.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive DM grants allowed while IF is pending before IF is forced a grant; range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- flush_i  in  1  branch taken (PC_Select); kills the pending or in-flight fetch.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched word; valid with if_ack_o.
- if_ack_o  out  1  one-cycle fetch-complete pulse.
- dm_req_i  in  1  data request; held until dm_ack_o.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  write data.
- dm_rdata_o  out  DATA_W  read data; valid with dm_ack_o.
- dm_ack_o  out  1  one-cycle data-complete pulse.
- mem_req_o  out  1  memory request; held until mem_ack_i.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data; valid with mem_ack_i.
- mem_ack_i  in  1  memory completion; single cycle; may arrive in the first mem_req_o cycle.

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE; all outputs 0; starve counter 0.
  - Asserting reset mid-access abandons the access with no ack. The memory must tolerate mem_req_o dropping.
- FSM states: IDLE, IF_BUSY, DM_BUSY, DRAIN.
- IDLE grant decision (registered):
  - A requester whose ack is high this cycle is not eligible.
  - if_req_i is ineligible while flush_i=1.
  - Both eligible: DM wins unless starve_cnt==STARVE_MAX, in which case IF wins.
  - Grant IF -> IF_BUSY; grant DM -> DM_BUSY.
  - On grant, latch addr/we/wdata into mem_*_o and set mem_req_o=1 at the same edge. mem_we_o is always 0 for IF.
- IF_BUSY/DM_BUSY:
  - Hold mem_* stable until mem_ack_i.
  - On mem_ack_i: capture mem_rdata_i into the requester's rdata register, pulse its ack in the following cycle, clear mem_req_o, return to IDLE.
- Flush:
  - flush_i in IF_BUSY without mem_ack_i -> DRAIN.
  - flush_i in IF_BUSY with mem_ack_i -> IDLE with no if_ack.
  - DRAIN: wait for mem_ack_i, discard the data, no ack, -> IDLE.
- if_ack_o = if_ack_q & ~flush_i, so a flush in the ack cycle also suppresses it. dm_ack_o is never affected by flush_i.
- Latency: request seen in cycle N -> mem_req_o in N+1. With mem_ack_i in N+1, ack is in N+2 and the next grant decision is also in N+2. Minimum 3 cycles per access; no pipelining of accesses.
- Starve counter (4 bits):
  - Increments on each DM grant while if_req_i=1.
  - Clears on IF grant or whenever if_req_i=0.
  - Saturates at STARVE_MAX.
- Outputs are held between accesses (the rdata registers keep their last value).

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Enabled: adds outputs perf_if_wait_o[31:0] and perf_dm_wait_o[31:0].
  - Each counts cycles with req high and ack low, saturating at 0xFFFFFFFF.
  - Both are cleared by rst_i.
- Disabled: the ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, IF_BUSY, DM_BUSY, DRAIN);
  - the 4-bit starve counter width;
  - the perf counter width (32).
- One sub-module, mem_arb_perf_cnt: saturating counter with enable. Instantiated twice, only under MEM_ARB_PERF_EN.

Test Plan:
- Lone fetch: if_req_i=1, addr 0x40 in cycle 0; memory acks in cycle 1 with 0xDEADBEEF -> mem_req_o high in cycle 1 only, if_ack_o pulses in cycle 2 with if_rdata_o=0xDEADBEEF.
- Simultaneous: if_req_i and dm_req_i (write 0x11 to 0x80) in the same cycle -> DM granted first (mem_we_o=1, addr 0x80), IF granted in the ack cycle of the DM access.
- Starvation: DM requests back-to-back with IF held high and STARVE_MAX=4 -> exactly 4 DM grants, then IF granted, then the counter resets.
- Flush in flight: IF granted, memory ack delayed 3 cycles, flush_i pulsed in cycle 2 -> state DRAIN, no if_ack_o, next grant after mem_ack_i.
- Mid-access reset: rst_i asserted during DM_BUSY -> all outputs 0 immediately, no dm_ack_o; a new DM request after reset completes normally.
- Perf (MEM_ARB_PERF_EN): IF waits behind a 3-cycle DM access -> perf_if_wait_o increments by the exact number of stalled cycles (5 for ack-in-cycle-3 latency).
